// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the BCD stopwatch.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned DEF_CLK_HZ          = 48000000;
   localparam int unsigned DEF_TICK_HZ         = 1;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 480000;

   localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer and press-edge pulse.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   // cnt tracks how long sync_q2 has disagreed with level; any agreement restarts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         level   <= 1'b1;
         level_q <= 1'b1;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
         level_q <= level;
         press   <= level_q & ~level;
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            level <= sync_q2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// Two-digit BCD seconds stopwatch with debounced start/stop and clear buttons.
//
// state    | meaning
// ST_IDLE  | cleared, digits 00, prescaler 0, waiting for start
// ST_RUN   | prescaler counting, digits advance each tick
// ST_PAUSE | prescaler and digits frozen, start resumes
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
   parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_start_n,
   input  logic btn_clear_n,
   output bcd_t tens,
   output bcd_t ones,
   output logic digits_valid,
   output logic running,
   output logic wrap
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

   sw_state_t     state;
   sw_state_t     state_nxt;
   logic [PW-1:0] presc;
   logic          start_press;
   logic          clr_press;
   logic          tick;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_start_n),
      .press (start_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_clear_n),
      .press (clr_press)
   );

   assign tick    = (state == ST_RUN) && (presc == PRE_TC);
   assign running = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr_press) begin
         state_nxt = ST_IDLE;
      end else if (start_press) begin
         case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // >= 9 compares keep the digits inside 0..9 even from a corrupted value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens         <= '0;
         ones         <= '0;
         presc        <= '0;
         digits_valid <= 1'b0;
         wrap         <= 1'b0;
      end else begin
         digits_valid <= 1'b0;
         wrap         <= 1'b0;
         if (clr_press) begin
            tens         <= '0;
            ones         <= '0;
            presc        <= '0;
            digits_valid <= 1'b1;
         end else if (state == ST_RUN) begin
            if (tick) begin
               presc        <= '0;
               digits_valid <= 1'b1;
               if (ones >= BCD_NINE) begin
                  ones <= '0;
                  if (tens >= BCD_NINE) begin
                     tens <= '0;
                     wrap <= 1'b1;
                  end else begin
                     tens <= tens + 4'd1;
                  end
               end else begin
                  ones <= ones + 4'd1;
               end
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

endmodule
